// File: rtl/mu0_mem_resp.sv
// MU0 memory responder: 4096x16 store, programmable wait states, Ready pulse.
// Optional write protection above PROTECT_BASE via `define MU0_MEM_PROTECT_EN.
module mu0_mem_resp #(
  parameter int         WAIT_STATES  = 1,
  parameter logic [11:0] PROTECT_BASE = 12'hF00
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [11:0] Address,
  input  logic [15:0] Din,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] Dout,
  output logic        Ready,
  output logic        Busy,
  output logic        Fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic        blk_q, blk_d;
  logic [15:0] dout_q;

  logic        acc;
  logic [11:0] acc_addr;
  logic [15:0] acc_din;
  logic        acc_wr;
  logic        acc_blk;
  logic        req_blk;

  logic [15:0] mem [4096];

`ifdef MU0_MEM_PROTECT_EN
  assign req_blk = Wr & (Address >= PROTECT_BASE);
`else
  assign req_blk = Wr & (Address >= PROTECT_BASE) & 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    blk_d    = blk_q;
    acc      = 1'b0;
    acc_addr = addr_q;
    acc_din  = din_q;
    acc_wr   = wr_q;
    acc_blk  = blk_q;
    unique case (state_q)
      IDLE: begin
        if (Rd | Wr) begin
          addr_d = Address;
          din_d  = Din;
          wr_d   = Wr;
          blk_d  = req_blk;
          cnt_d  = WS;
          if (WS == 4'd0) begin
            // zero wait states: access on the accepting edge itself
            state_d  = DONE;
            acc      = 1'b1;
            acc_addr = Address;
            acc_din  = Din;
            acc_wr   = Wr;
            acc_blk  = req_blk;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          acc     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 12'h000;
      din_q   <= 16'h0000;
      wr_q    <= 1'b0;
      blk_q   <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      blk_q   <= blk_d;
      if (acc && !acc_wr)
        dout_q <= mem[acc_addr];
    end
  end

  // array is never reset; a reset edge only suppresses the pending write
  always_ff @(posedge Clk) begin
    if (nReset && acc && acc_wr && !acc_blk)
      mem[acc_addr] <= acc_din;
  end

  assign Dout  = dout_q;
  assign Ready = (state_q == DONE);
  assign Busy  = (state_q != IDLE);
  assign Fault = (state_q == DONE) & blk_q;

endmodule

// File: tb/tb_mu0_mem_resp.sv
// Directed bench for mu0_mem_resp: one instance with 1 wait state, one with 0.
// Protection cases run only when MU0_MEM_PROTECT_EN is defined.
module tb_mu0_mem_resp;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;

  logic [11:0] a1 = '0;
  logic [15:0] d1 = '0;
  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [15:0] q1;
  logic        rdy1, bsy1, flt1;

  logic [11:0] a0 = '0;
  logic [15:0] d0 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [15:0] q0;
  logic        rdy0, bsy0, flt0;

  int errs = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mu0_mem_resp #(.WAIT_STATES(1)) u_ws1 (
    .Clk(Clk), .nReset(nReset), .Address(a1), .Din(d1),
    .Rd(rd1), .Wr(wr1), .Dout(q1), .Ready(rdy1),
    .Busy(bsy1), .Fault(flt1)
  );

  mu0_mem_resp #(.WAIT_STATES(0)) u_ws0 (
    .Clk(Clk), .nReset(nReset), .Address(a0), .Din(d0),
    .Rd(rd0), .Wr(wr0), .Dout(q0), .Ready(rdy0),
    .Busy(bsy0), .Fault(flt0)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // full WAIT_STATES=1 transaction; addr_after is applied after acceptance
  task automatic acc1(input string tag, input logic r, input logic w,
                      input logic [11:0] a, input logic [15:0] d,
                      input logic [11:0] addr_after,
                      input logic [15:0] exp_q, input logic exp_f);
    rd1 = r; wr1 = w; a1 = a; d1 = d;
    tick();
    rd1 = 1'b0; wr1 = 1'b0; a1 = addr_after; d1 = ~d;
    chk({tag, ".wait_busy"}, 16'(bsy1), 16'd1);
    chk({tag, ".wait_rdy"}, 16'(rdy1), 16'd0);
    tick();
    chk({tag, ".rdy"}, 16'(rdy1), 16'd1);
    chk({tag, ".busy"}, 16'(bsy1), 16'd1);
    chk({tag, ".fault"}, 16'(flt1), 16'(exp_f));
    chk({tag, ".dout"}, q1, exp_q);
    tick();
    chk({tag, ".idle_rdy"}, 16'(rdy1), 16'd0);
    chk({tag, ".idle_busy"}, 16'(bsy1), 16'd0);
    chk({tag, ".hold"}, q1, exp_q);
  endtask

  task automatic acc0_wr(input string tag, input logic [11:0] a,
                         input logic [15:0] d);
    wr0 = 1'b1; a0 = a; d0 = d;
    tick();
    wr0 = 1'b0;
    chk({tag, ".rdy"}, 16'(rdy0), 16'd1);
    chk({tag, ".busy"}, 16'(bsy0), 16'd1);
    tick();
    chk({tag, ".idle"}, 16'(rdy0), 16'd0);
  endtask

  initial begin
    logic [15:0] prior;
    nReset = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    chk("rst.rdy", 16'(rdy1), 16'd0);
    chk("rst.busy", 16'(bsy1), 16'd0);
    chk("rst.fault", 16'(flt1), 16'd0);
    chk("rst.dout", q1, 16'h0000);
    chk("rst0.busy", 16'(bsy0), 16'd0);
    chk("rst0.dout", q0, 16'h0000);

    acc1("wr010", 0, 1, 12'h010, 16'hA5C3, 12'h010, 16'h0000, 0);
    acc1("rd010", 1, 0, 12'h010, 16'h0000, 12'h010, 16'hA5C3, 0);
    acc1("wr020", 0, 1, 12'h020, 16'h0BEE, 12'h020, 16'hA5C3, 0);
    acc1("rd020", 1, 0, 12'h020, 16'h0000, 12'h020, 16'h0BEE, 0);
    acc1("addrchg", 1, 0, 12'h010, 16'h0000, 12'h020, 16'hA5C3, 0);
    acc1("rdwr030", 1, 1, 12'h030, 16'h1234, 12'h030, 16'hA5C3, 0);
    acc1("rd030", 1, 0, 12'h030, 16'h0000, 12'h030, 16'h1234, 0);

    // reset pulse lands on the access edge of a pending write
    wr1 = 1'b1; a1 = 12'h010; d1 = 16'hDEAD;
    tick();
    wr1 = 1'b0;
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    chk("rstwait.busy", 16'(bsy1), 16'd0);
    chk("rstwait.rdy", 16'(rdy1), 16'd0);
    chk("rstwait.dout", q1, 16'h0000);
    tick();
    chk("rstwait.idle", 16'(bsy1), 16'd0);
    acc1("rd010b", 1, 0, 12'h010, 16'h0000, 12'h010, 16'hA5C3, 0);

`ifdef MU0_MEM_PROTECT_EN
    acc1("wrEFF", 0, 1, 12'hEFF, 16'h4321, 12'hEFF, 16'hA5C3, 0);
    acc1("rdEFF", 1, 0, 12'hEFF, 16'h0000, 12'hEFF, 16'h4321, 0);
    rd1 = 1'b1; a1 = 12'hF05;
    tick();
    rd1 = 1'b0;
    tick();
    prior = q1;
    tick();
    acc1("wrF05", 0, 1, 12'hF05, ~prior, 12'hF05, prior, 1);
    acc1("wrF05ff", 0, 1, 12'hF05, 16'hFFFF, 12'hF05, prior, 1);
    acc1("rdF05", 1, 0, 12'hF05, 16'h0000, 12'hF05, prior, 0);
`endif

    acc0_wr("w0_000", 12'h000, 16'h1111);
    acc0_wr("w0_001", 12'h001, 16'h2222);
    chk("w0.dout", q0, 16'h0000);
    rd0 = 1'b1; a0 = 12'h000;
    tick();
    a0 = 12'h001;
    chk("b2b.rdy1", 16'(rdy0), 16'd1);
    chk("b2b.dout1", q0, 16'h1111);
    tick();
    chk("b2b.gap", 16'(rdy0), 16'd0);
    chk("b2b.gapbusy", 16'(bsy0), 16'd0);
    tick();
    rd0 = 1'b0;
    chk("b2b.rdy2", 16'(rdy0), 16'd1);
    chk("b2b.dout2", q0, 16'h2222);
    tick();
    chk("b2b.end", 16'(rdy0), 16'd0);
    chk("b2b.hold", q0, 16'h2222);
    chk("ws0.fault", 16'(flt0), 16'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mu0_mem_resp.md
# mu0_mem_resp

Memory responder for the MU0 processor: the far end of the 12-bit address path. It accepts read and write requests from the MU0 datapath and controller, and holds a 4096 x 16 word store. It inserts a programmable number of wait states, performs the access, and returns a one-cycle Ready pulse with read data. It lets the MU0 control FSM be exercised against a memory that is not single-cycle.

## Interface
Parameters:
- WAIT_STATES, default 1: number of wait cycles between request acceptance and access completion; legal range 0..15.
- PROTECT_BASE, default 12'hF00: lowest write-protected address; used only when MU0_MEM_PROTECT_EN is defined.

Ports:
- Clk  input  1  single clock; all state changes on the rising edge.
- nReset  input  1  reset is synchronous and active-low; one clock; sampled on the rising edge of Clk.
- Address  input  12  word address from the MU0 address multiplexer; sampled only at request acceptance.
- Din  input  16  write data; sampled only at request acceptance.
- Rd  input  1  read request.
- Wr  input  1  write request.
- Dout  output  16  read data; reset 16'h0000; holds its value until the next completed read.
- Ready  output  1  completion pulse; reset 0.
- Busy  output  1  high in every state except IDLE; reset 0.
- Fault  output  1  pulses with Ready on a blocked write; reset 0; tied 0 without MU0_MEM_PROTECT_EN.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, with Rd or Wr high at the edge:
  - latch Address, Din and operation into internal registers;
  - load the wait counter with WAIT_STATES;
  - go to WAIT, or go directly to DONE when WAIT_STATES = 0.
- IDLE with Rd = Wr = 0: stay in IDLE.
- WAIT: decrement the counter each edge. On the edge where the counter reaches 1:
  - perform the access using the latched values: a write stores the word, a read loads Dout;
  - go to DONE.
- DONE: Ready = 1 for exactly one cycle, then return to IDLE on the next edge.
- Requests arriving in WAIT or DONE are ignored, not queued. The requester must hold or re-issue them once Busy is low.
- Rd and Wr both high at acceptance: the request is a write and Dout is unchanged.
- Address and Din changes after acceptance have no effect on the access in progress.
- Memory array: not reset, so contents survive nReset; the initial content is undefined (X in simulation).
- nReset low in any state:
  - next state is IDLE; Ready, Busy, Fault and Dout are cleared;
  - a pending access is abandoned and its memory write does not occur.

## Timing
- Request sampled at edge t:
  - the access happens at edge t+WAIT_STATES (for WAIT_STATES = 0, the access happens at edge t itself);
  - Ready is high for the single cycle following that edge.
- Busy is high from the cycle after edge t through the Ready cycle inclusive.
- Read data is valid on Dout in the Ready cycle and stays stable afterwards.
- Maximum throughput: one access per WAIT_STATES+2 cycles, since IDLE must be re-entered for one edge.
- Request held continuously high: it is re-accepted at the first edge in IDLE after DONE, giving repeated accesses.

## Configuration
- MU0_MEM_PROTECT_EN defined:
  - a write whose latched Address is >= PROTECT_BASE does not modify memory;
  - Fault is high in the same cycle as Ready for that access;
  - reads are unaffected by protection.
- MU0_MEM_PROTECT_EN undefined:
  - all addresses are writable;
  - Fault is constant 0;
  - PROTECT_BASE is ignored.

## Test plan
- Reset: hold nReset low for 2 cycles -> Ready = 0, Busy = 0, Fault = 0, Dout = 16'h0000, FSM in IDLE.
- WAIT_STATES = 1, write then read:
  - write 16'hA5C3 to 12'h010 with a one-cycle Wr pulse -> Ready pulses 2 cycles after the request edge;
  - read 12'h010 -> Dout = 16'hA5C3 in its Ready cycle.
- WAIT_STATES = 0, back-to-back reads of 12'h000 and 12'h001 with Rd held high -> Ready pulses every 2 cycles, carrying the two stored words in order.
- Address changed to 12'h020 during WAIT after a read request for 12'h010 -> returned data is from 12'h010.
- Rd = Wr = 1 at 12'h030 with Din = 16'h1234 -> memory[12'h030] = 16'h1234 and Dout is unchanged.
- With MU0_MEM_PROTECT_EN defined:
  - write 16'hFFFF to 12'hF05 -> Fault and Ready are high together and a readback returns the prior value;
  - pulse nReset during WAIT -> no write occurs and the FSM is in IDLE on the next cycle.
